// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: received-byte stream in, instruction-memory write bus out
// master: loader side (consumes rx_done/rx_data, drives mem_we/mem_addr/mem_data)
// slave: environment side (UART receiver plus instruction memory)
interface uart_program_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 10
);
  logic               rx_done;
  logic [NB_DATA-1:0] rx_data;
  logic               mem_we;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_WORD-1:0] mem_data;
  modport master (input rx_done, rx_data, output mem_we, mem_addr, mem_data);
  modport slave (output rx_done, rx_data, input mem_we, mem_addr, mem_data);
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: assembles MSB-first bytes after a load command into words written to instruction memory
// i_clk/i_rst: clock, synchronous active-low reset
// bus: byte stream in, memory write strobe/address/data out
// o_loading/o_load_done: state flags; o_overflow: memory filled before halt; o_cpu_en: clean completion
// o_word_count: words written in the current or last load
module uart_program_loader #(
  parameter int                 NB_DATA   = 8,
  parameter int                 NB_WORD   = 32,
  parameter int                 NB_ADDR   = 10,
  parameter logic [NB_DATA-1:0] CMD_LOAD  = 8'h4C,
  parameter logic [NB_WORD-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_program_loader_if.master bus,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic                 o_overflow,
  output logic                 o_cpu_en,
  output logic [NB_ADDR:0]     o_word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [NB_WORD-1:0] word;
  logic [NB_WORD-1:0] shifted;
  logic [1:0]         byte_cnt;
  logic               pend_we;
  logic               pend_halt;
  logic               pend_last;
  logic [NB_ADDR-1:0] addr;
  logic               start;
  logic               take;
  // a command byte only restarts outside LOAD; inside LOAD it is plain data
  assign start   = bus.rx_done && bus.rx_data == CMD_LOAD && state != LOAD;
  assign take    = bus.rx_done && state == LOAD;
  assign shifted = {word[NB_WORD-NB_DATA-1:0], bus.rx_data};
  // the write strobe is the pending flag itself, so it lands one cycle after the 4th byte
  assign bus.mem_we   = pend_we;
  assign bus.mem_addr = addr;
  assign bus.mem_data = word;
  always_ff @(posedge i_clk)
    state <= !i_rst ? IDLE : state_nx;
  always_comb
    state_nx = start ? LOAD :
               (state == LOAD && pend_we && (pend_halt || pend_last)) ? DONE : state;
  always_comb begin
    o_loading   = state == LOAD;
    o_load_done = state == DONE;
    o_cpu_en    = o_load_done && !o_overflow;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      word         <= '0;
      byte_cnt     <= '0;
      pend_we      <= 1'b0;
      pend_halt    <= 1'b0;
      pend_last    <= 1'b0;
      addr         <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (start) begin
        addr         <= '0;
        o_word_count <= '0;
        byte_cnt     <= '0;
        o_overflow   <= 1'b0;
      end
      // byte capture runs independently of the write cycle so back-to-back bytes are never lost
      if (take) begin
        word     <= shifted;
        byte_cnt <= byte_cnt + 2'd1;
      end
      pend_we <= take && byte_cnt == 2'd3;
      if (take && byte_cnt == 2'd3) begin
        pend_halt <= shifted == HALT_WORD;
        pend_last <= addr == {NB_ADDR{1'b1}};
      end
      if (pend_we) begin
        addr         <= addr + 1'b1;
        o_word_count <= o_word_count + 1'b1;
        if (!pend_halt && pend_last) o_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed checks of command filtering, word assembly, halt, overflow, reset and reload
module tb_uart_program_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  int         n_chk = 0;
  int         n_pass = 0;
  always #5 clk = ~clk;
  uart_program_loader_if #(.NB_ADDR(10)) b1 ();
  uart_program_loader_if #(.NB_ADDR(2))  b2 ();
  assign b1.rx_done = rx_done;
  assign b1.rx_data = rx_data;
  assign b2.rx_done = rx_done;
  assign b2.rx_data = rx_data;
  logic        loading1, done1, ovf1, cpu1;
  logic [10:0] cnt1;
  logic        loading2, done2, ovf2, cpu2;
  logic [2:0]  cnt2;
  uart_program_loader #(.NB_ADDR(10)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(b1),
    .o_loading(loading1), .o_load_done(done1), .o_overflow(ovf1),
    .o_cpu_en(cpu1), .o_word_count(cnt1)
  );
  uart_program_loader #(.NB_ADDR(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(b2),
    .o_loading(loading2), .o_load_done(done2), .o_overflow(ovf2),
    .o_cpu_en(cpu2), .o_word_count(cnt2)
  );
  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  logic [1:0]  wa2[$];
  always @(posedge clk) begin
    if (b1.mem_we) begin
      wa.push_back(b1.mem_addr);
      wd.push_back(b1.mem_data);
    end
    if (b2.mem_we) wa2.push_back(b2.mem_addr);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic clear_log();
    wa.delete();
    wd.delete();
    wa2.delete();
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_flags", {loading1, done1, ovf1, cpu1, b1.mem_we}, 0);
    chk("reset_addr", b1.mem_addr, 0);
    chk("reset_data", b1.mem_data, 0);
    chk("reset_count", cnt1, 0);
    rst = 1'b1;
    send(8'h00);
    send(8'h11);
    send(8'hFF);
    @(negedge clk);
    chk("filter_loading", loading1, 0);
    chk("filter_writes", wa.size(), 0);
    send(8'h4C);
    chk("cmd_loading", loading1, 1);
    send_word(32'h2008_0005);
    chk("w0_we", b1.mem_we, 1);
    chk("w0_addr", b1.mem_addr, 0);
    chk("w0_data", b1.mem_data, 32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    chk("halt_we", b1.mem_we, 1);
    chk("halt_addr", b1.mem_addr, 1);
    chk("halt_data", b1.mem_data, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("basic_done", {done1, cpu1, ovf1, loading1, b1.mem_we}, 5'b11000);
    chk("basic_count", cnt1, 2);
    chk("basic_nwr", wa.size(), 2);
    chk("basic_wr0", {wa[0], wd[0]}, {10'd0, 32'h2008_0005});
    chk("basic_wr1", {wa[1], wd[1]}, {10'd1, 32'hFFFF_FFFF});
    send(8'h4C);
    chk("reload_cpu_drop", {cpu1, done1, loading1}, 3'b001);
    chk("reload_count_clr", cnt1, 0);
    clear_log();
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    @(negedge clk);
    chk("reload_done", {done1, cpu1, ovf1}, 3'b110);
    chk("reload_count", cnt1, 2);
    chk("reload_wr0", {wa[0], wd[0]}, {10'd0, 32'h0000_0001});
    chk("reload_wr1", {wa[1], wd[1]}, {10'd1, 32'hFFFF_FFFF});
    send(8'h4C);
    clear_log();
    send_word(32'h4C4C_4C4C);
    @(negedge clk);
    chk("cmd_as_data_loading", loading1, 1);
    chk("cmd_as_data_count", cnt1, 1);
    chk("cmd_as_data_nwr", wa.size(), 1);
    chk("cmd_as_data_wr", {wa[0], wd[0]}, {10'd0, 32'h4C4C_4C4C});
    do_reset();
    send(8'h4C);
    clear_log();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) chk("b2b_we0", {b1.mem_we, b1.mem_addr, b1.mem_data}, {1'b1, 10'd0, 32'h0102_0304});
      if (i == 6) chk("b2b_we_pulse", b1.mem_we, 0);
      rx_done = 1'b1;
      rx_data = 8'(i);
    end
    @(negedge clk);
    rx_done = 1'b0;
    chk("b2b_we1", {b1.mem_we, b1.mem_addr, b1.mem_data}, {1'b1, 10'd1, 32'h0506_0708});
    @(negedge clk);
    chk("b2b_nwr", wa.size(), 2);
    do_reset();
    send(8'h4C);
    clear_log();
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    chk("ovf_not_yet", {ovf2, loading2}, 2'b01);
    send_word(32'h4444_4444);
    chk("ovf_last_we", {b2.mem_we, b2.mem_addr}, {1'b1, 2'd3});
    @(negedge clk);
    chk("ovf_state", {done2, ovf2, cpu2, loading2}, 4'b1100);
    chk("ovf_count", cnt2, 4);
    chk("ovf_nwr", wa2.size(), 4);
    chk("ovf_addrs", {wa2[0], wa2[1], wa2[2], wa2[3]}, 8'b00_01_10_11);
    chk("ovf_big_mem_loading", {loading1, cnt1}, {1'b1, 11'd4});
    send(8'h4C);
    chk("ovf_cleared", {ovf2, loading2, cpu2}, 3'b010);
    do_reset();
    send(8'h4C);
    clear_log();
    send_word(32'hA1A2_A3A4);
    send_word(32'hB1B2_B3B4);
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = 8'hC4;
    rst = 1'b0;
    @(negedge clk);
    rx_done = 1'b0;
    rst = 1'b1;
    chk("midrst_flags", {loading1, done1, ovf1, cpu1, b1.mem_we}, 0);
    chk("midrst_bus", {b1.mem_addr, b1.mem_data}, 0);
    chk("midrst_count", cnt1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_write", wa.size(), 2);
    send(8'h4C);
    clear_log();
    send_word(32'h0BAD_F00D);
    chk("midrst_restart", {b1.mem_we, b1.mem_addr, b1.mem_data}, {1'b1, 10'd0, 32'h0BAD_F00D});
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
